rf_write_arbiter: RTL and testbench

//  Controller for the single write port of the 32x32 Register_Files block.
//  - After reset, or on a clear request, it sequences a zero-fill of every register.
//  - It then arbitrates round-robin between two writeback requesters (ALU, MEM)

---
 rtl/rf_write_arbiter.sv | 122 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: controller for the single write port of the register file.
// After reset, or on clr_req, it zero-fills every register one per cycle (INIT).
// In RUN it grants the ALU and MEM writeback requesters round-robin.
// Optional feature macro: RF_SCOREBOARD_EN adds a per-register busy scoreboard.
// Without the macro, busy is tied to 0.
module rf_write_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREG   = 32
) (
   input  logic              CLK,
   input  logic              Reset_n,
   input  logic              clr_req,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              mem_ready,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_addr,
   output logic [NREG-1:0]   busy,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] R_W,
   output logic [DATA_W-1:0] W,
   output logic              init_done
);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
   localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREG - 1);

   logic [0:0]        state;
   logic [ADDR_W-1:0] cnt;
   logic              prio;      // 0: ALU wins a tie, 1: MEM wins a tie
   logic              alu_win;
   logic              mem_win;
   logic              grant_en;
   logic              xfer;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   // Winner selection and combinational readies; no grants in INIT or while clearing
   always_comb begin
      alu_win   = alu_valid & (~mem_valid | ~prio);
      mem_win   = mem_valid & ~alu_win;
      grant_en  = (state == ST_RUN) & ~clr_req;
      alu_ready = grant_en & alu_win;
      mem_ready = grant_en & mem_win;
      xfer      = alu_ready | mem_ready;
      wr_addr   = mem_ready ? mem_addr : alu_addr;
      wr_data   = mem_ready ? mem_data : alu_data;
   end

   // Zero-fill sequencer, registered write port and round-robin pointer
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= ST_INIT;
         cnt       <= '0;
         prio      <= 1'b0;
         RegWrite  <= 1'b0;
         R_W       <= '0;
         W         <= '0;
         init_done <= 1'b0;
      end else if (state == ST_INIT) begin
         RegWrite <= 1'b1;
         R_W      <= cnt;
         W        <= '0;
         cnt      <= cnt + 1'b1;
         if (cnt == LAST_REG) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
         end
      end else if (clr_req) begin
         state     <= ST_INIT;
         cnt       <= '0;
         init_done <= 1'b0;
         RegWrite  <= 1'b0;
      end else if (xfer) begin
         // r0 is hardwired: the handshake completes but the write is dropped
         RegWrite <= (wr_addr != '0);
         R_W      <= wr_addr;
         W        <= wr_data;
         prio     <= alu_ready;   // the loser gets the next tie
      end else begin
         RegWrite <= 1'b0;
      end
   end

`ifdef RF_SCOREBOARD_EN
   logic [NREG-1:0] busy_set;
   logic [NREG-1:0] busy_clr;

   // Per-edge set/clear masks; r0 is never tracked
   always_comb begin
      busy_set = '0;
      busy_clr = '0;
      if (state == ST_RUN && issue_valid && issue_addr != '0)
         busy_set[issue_addr] = 1'b1;
      if (xfer)
         busy_clr[wr_addr] = 1'b1;
   end

   // Pending-write scoreboard; a new issue beats a same-edge writeback
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n)
         busy <= '0;
      else if (state == ST_RUN && clr_req)
         busy <= '0;
      else
         busy <= (busy & ~busy_clr) | busy_set;
   end
`else
   logic unused_issue;

   assign busy         = '0;
   assign unused_issue = ^{issue_valid, issue_addr};
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed vectors, expected writes queued by the stimulus
// and popped by a monitor whenever the register file write enable is seen.
module tb_rf_write_arbiter;

`ifdef RF_SCOREBOARD_EN
   localparam logic SB = 1'b1;
`else
   localparam logic SB = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        Reset_n;
   logic        clr_req, alu_valid, mem_valid, issue_valid;
   logic [4:0]  alu_addr, mem_addr, issue_addr;
   logic [31:0] alu_data, mem_data;
   logic        alu_ready, mem_ready;
   logic [31:0] busy;
   logic        RegWrite, init_done;
   logic [4:0]  R_W;
   logic [31:0] W;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      logic        idn;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   rf_write_arbiter dut (
      .CLK(CLK), .Reset_n(Reset_n), .clr_req(clr_req),
      .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
      .issue_valid(issue_valid), .issue_addr(issue_addr), .busy(busy),
      .RegWrite(RegWrite), .R_W(R_W), .W(W), .init_done(init_done)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every register-file write must match the head of the queue
   always @(negedge CLK) begin
      if (Reset_n === 1'b1 && RegWrite === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write_addr", {27'd0, R_W}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("write_addr", {27'd0, R_W}, {27'd0, e.a});
            chk("write_data", W, e.d);
            chk("write_init_done", {31'd0, init_done}, {31'd0, e.idn});
         end
      end
   end

   task automatic push_init();
      for (int i = 0; i < 32; i++)
         exp_q.push_back('{a: 5'(i), d: 32'd0, idn: (i == 31)});
   endtask

   // One cycle: drive at posedge+1, check readies at posedge+4, queue expected writes
   task automatic cyc(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic clr, input logic iv, input logic [4:0] ia,
                      input logic ear, input logic emr, input string tag);
      alu_valid = av; alu_addr = aa; alu_data = ad;
      mem_valid = mv; mem_addr = ma; mem_data = md;
      clr_req = clr; issue_valid = iv; issue_addr = ia;
      #3;
      chk({tag, "_alu_ready"}, {31'd0, alu_ready}, {31'd0, ear});
      chk({tag, "_mem_ready"}, {31'd0, mem_ready}, {31'd0, emr});
      if (ear && aa != 5'd0) exp_q.push_back('{a: aa, d: ad, idn: 1'b1});
      if (emr && ma != 5'd0) exp_q.push_back('{a: ma, d: md, idn: 1'b1});
      @(posedge CLK); #1;
   endtask

   task automatic idle(input string tag);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
   endtask

   initial begin
      Reset_n = 1'b0; clr_req = 0; alu_valid = 0; mem_valid = 0; issue_valid = 0;
      alu_addr = 0; mem_addr = 0; issue_addr = 0; alu_data = 0; mem_data = 0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_RegWrite", {31'd0, RegWrite}, 0);
      chk("rst_R_W", {27'd0, R_W}, 0);
      chk("rst_W", W, 0);
      chk("rst_init_done", {31'd0, init_done}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_alu_ready", {31'd0, alu_ready}, 0);

      // Zero-fill: ALU request and an issue held throughout, both must be ignored
      Reset_n = 1'b1;
      push_init();
      for (int i = 0; i < 32; i++)
         cyc(1, 3, 32'h1234, 0, 0, 0, 0, 1, 7, 0, 0, "init1");
      chk("init1_busy", busy, 0);

      // Lone ALU request in RUN
      cyc(1, 3, 32'h1234, 0, 0, 0, 0, 0, 0, 1, 0, "alu_solo");
      idle("idle1");
      // Lone MEM request, hands the tie back to ALU
      cyc(0, 0, 0, 1, 4, 32'h44, 0, 0, 0, 0, 1, "mem_solo");

      // Both valid: ALU, MEM, ALU, MEM
      for (int k = 0; k < 4; k++)
         cyc(1, 1, 32'hA000 + k, 1, 2, 32'hB000 + k, 0, 0, 0,
             (k % 2 == 0), (k % 2 == 1), "rr");

      // Address 0: accepted, dropped, but the tie still moves to MEM
      cyc(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 1, 0, "addr0");
      cyc(1, 1, 32'hC1, 1, 2, 32'hC2, 0, 0, 0, 0, 1, "after0");
      idle("idle2");

      // Scoreboard: issue 5, write+reissue 5, lone write 5
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, "issue5");
      chk("busy5_set", {31'd0, busy[5]}, {31'd0, SB});
      cyc(1, 5, 32'h55, 0, 0, 0, 0, 1, 5, 1, 0, "wr_reissue5");
      chk("busy5_set_wins", {31'd0, busy[5]}, {31'd0, SB});
      cyc(1, 5, 32'h56, 0, 0, 0, 0, 0, 0, 1, 0, "wr5");
      chk("busy5_clear", busy, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "issue0");
      chk("busy_addr0", busy, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, "issue6");
      chk("busy6_set", busy, {25'd0, SB, 6'd0});

      // Clear while MEM is requesting: refused, zero-fill repeats, then accepted
      push_init();
      cyc(0, 0, 0, 1, 9, 32'h99, 1, 0, 0, 0, 0, "clr");
      chk("clr_init_done", {31'd0, init_done}, 0);
      chk("clr_RegWrite", {31'd0, RegWrite}, 0);
      chk("clr_busy", busy, 0);
      for (int i = 0; i < 32; i++)
         cyc(0, 0, 0, 1, 9, 32'h99, 0, 1, 7, 0, 0, "init2");
      chk("init2_busy", busy, 0);
      cyc(0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 0, 1, "mem_after_clr");
      repeat (3) idle("drain");
      chk("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
